// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with valid/ready handshake, 2-entry skid storage and synchronous flush.
// Latency 1 cycle; sustains 1 instr/cycle while decode keeps up.
// Backpressure: out_ready = ~skid_valid, so it comes from state only (no comb path from inp_ready).
//
// Ports:
//   inp_clk / inp_rst                         clock (rising edge), async active-high reset
//   inp_instruction, inp_address, inp_valid   fetch side; out_ready back to fetch
//   inp_flush                                 discard held and same-cycle incoming entries
//   out_instruction, out_address, out_valid   decode side; inp_ready from decode
//   out_stall_count, out_flush_count          only when IF_ID_PERF_CNT_EN is defined
//
// Optional feature macro: IF_ID_PERF_CNT_EN (saturating stall/flush perf counters).

module if_id_skid_reg #(
    parameter int unsigned        INSTR_W   = 16,
    parameter int unsigned        ADDR_W    = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int unsigned        CNT_W     = 16
) (
    input  logic               inp_clk,
    input  logic               inp_rst,
    input  logic [INSTR_W-1:0] inp_instruction,
    input  logic [ADDR_W-1:0]  inp_address,
    input  logic               inp_valid,
    output logic               out_ready,
    input  logic               inp_flush,
    output logic [INSTR_W-1:0] out_instruction,
    output logic [ADDR_W-1:0]  out_address,
    output logic               out_valid,
    input  logic               inp_ready
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   out_stall_count,
    output logic [CNT_W-1:0]   out_flush_count
`endif
);

    // Main entry drives the outputs directly; skid entry absorbs one extra
    // instruction accepted while decode is stalled.
    logic               main_vld_q, main_vld_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [ADDR_W-1:0]  main_addr_q, main_addr_d;
    logic               skid_vld_q, skid_vld_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]  skid_addr_q, skid_addr_d;

    logic accept;
    logic drain;

    assign out_ready       = ~skid_vld_q;
    assign out_valid       = main_vld_q;
    assign out_instruction = main_instr_q;
    assign out_address     = main_addr_q;

    assign accept = inp_valid & ~skid_vld_q;
    assign drain  = main_vld_q & inp_ready;

    always_comb begin
        main_vld_d   = main_vld_q;
        main_instr_d = main_instr_q;
        main_addr_d  = main_addr_q;
        skid_vld_d   = skid_vld_q;
        skid_instr_d = skid_instr_q;
        skid_addr_d  = skid_addr_q;

        if (inp_flush) begin
            // Flush wins over everything, including a same-cycle accept.
            main_vld_d   = 1'b0;
            main_instr_d = NOP_INSTR;
            main_addr_d  = '0;
            skid_vld_d   = 1'b0;
            skid_instr_d = NOP_INSTR;
            skid_addr_d  = '0;
        end else if (!main_vld_q || drain) begin
            // Main slot frees up this edge. A full skid always refills it
            // first to keep order; accept cannot coincide with a full skid
            // because out_ready is low then.
            if (skid_vld_q) begin
                main_vld_d   = 1'b1;
                main_instr_d = skid_instr_q;
                main_addr_d  = skid_addr_q;
                skid_vld_d   = 1'b0;
                skid_instr_d = NOP_INSTR;
                skid_addr_d  = '0;
            end else if (accept) begin
                main_vld_d   = 1'b1;
                main_instr_d = inp_instruction;
                main_addr_d  = inp_address;
            end else begin
                // Empty main holds NOP/0 so decode never sees stale data.
                main_vld_d   = 1'b0;
                main_instr_d = NOP_INSTR;
                main_addr_d  = '0;
            end
        end else if (accept) begin
            // Main is held by a stalled decode: park the new instruction.
            skid_vld_d   = 1'b1;
            skid_instr_d = inp_instruction;
            skid_addr_d  = inp_address;
        end
    end

    always_ff @(posedge inp_clk or posedge inp_rst) begin
        if (inp_rst) begin
            main_vld_q   <= 1'b0;
            main_instr_q <= NOP_INSTR;
            main_addr_q  <= '0;
            skid_vld_q   <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_addr_q  <= '0;
        end else begin
            main_vld_q   <= main_vld_d;
            main_instr_q <= main_instr_d;
            main_addr_q  <= main_addr_d;
            skid_vld_q   <= skid_vld_d;
            skid_instr_q <= skid_instr_d;
            skid_addr_q  <= skid_addr_d;
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (main_vld_q && !inp_ready && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        // Only flushes that actually discard a held entry are counted.
        if (inp_flush && (main_vld_q || skid_vld_q) && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge inp_clk or posedge inp_rst) begin
        if (inp_rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign out_stall_count = stall_cnt_q;
    assign out_flush_count = flush_cnt_q;
`else
    // Keeps CNT_W referenced when the counters are compiled out.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
module tb_if_id_skid_reg;

    localparam int W     = 16;
    localparam int CNT_W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  inp_instruction = '0;
    logic [W-1:0]  inp_address = '0;
    logic          inp_valid = 1'b0;
    logic          inp_flush = 1'b0;
    logic          inp_ready = 1'b0;
    logic          out_ready;
    logic [W-1:0]  out_instruction;
    logic [W-1:0]  out_address;
    logic          out_valid;
`ifdef IF_ID_PERF_CNT_EN
    logic [CNT_W-1:0] out_stall_count, out_flush_count;
    logic [1:0]       sm_stall_count, sm_flush_count;
    logic             sm_ready, sm_valid;
    logic [W-1:0]     sm_instr, sm_addr;
`endif

    always #5 clk = ~clk;

    if_id_skid_reg #(.INSTR_W(W), .ADDR_W(W), .NOP_INSTR(16'h0000), .CNT_W(CNT_W)) dut (
        .inp_clk(clk), .inp_rst(rst),
        .inp_instruction(inp_instruction), .inp_address(inp_address),
        .inp_valid(inp_valid), .out_ready(out_ready), .inp_flush(inp_flush),
        .out_instruction(out_instruction), .out_address(out_address),
        .out_valid(out_valid), .inp_ready(inp_ready)
`ifdef IF_ID_PERF_CNT_EN
        , .out_stall_count(out_stall_count), .out_flush_count(out_flush_count)
`endif
    );

`ifdef IF_ID_PERF_CNT_EN
    // Narrow-counter instance to exercise saturation.
    if_id_skid_reg #(.INSTR_W(W), .ADDR_W(W), .NOP_INSTR(16'h0000), .CNT_W(2)) dut_sat (
        .inp_clk(clk), .inp_rst(rst),
        .inp_instruction(inp_instruction), .inp_address(inp_address),
        .inp_valid(inp_valid), .out_ready(sm_ready), .inp_flush(inp_flush),
        .out_instruction(sm_instr), .out_address(sm_addr),
        .out_valid(sm_valid), .inp_ready(inp_ready),
        .out_stall_count(sm_stall_count), .out_flush_count(sm_flush_count)
    );
`endif

    // Reference model: the register is a FIFO of at most two entries whose
    // head is what decode sees.
    typedef struct packed { logic [W-1:0] instr; logic [W-1:0] addr; } ent_t;
    ent_t q[$];
    int   m_stall, m_flush, m_stall2, m_flush2;

    int errors = 0;
    int checks = 0;

    function automatic int sat(input int v, input int max);
        return (v + 1 > max) ? max : v + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        ent_t h;
        h = (q.size() > 0) ? q[0] : '0;
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk({tag, ".instr"}, {16'd0, out_instruction}, {16'd0, h.instr});
        chk({tag, ".addr"},  {16'd0, out_address}, {16'd0, h.addr});
        chk({tag, ".ready"}, {31'd0, out_ready}, {31'd0, q.size() < 2});
`ifdef IF_ID_PERF_CNT_EN
        chk({tag, ".stall"}, 32'(out_stall_count), 32'(m_stall));
        chk({tag, ".flush"}, 32'(out_flush_count), 32'(m_flush));
        chk({tag, ".stall2"}, 32'(sm_stall_count), 32'(m_stall2));
        chk({tag, ".flush2"}, 32'(sm_flush_count), 32'(m_flush2));
`endif
    endtask

    // Model update for one rising edge, using the inputs held across it.
    task automatic model_edge(input logic v, input logic [W-1:0] i, input logic [W-1:0] a,
                              input logic r, input logic f);
        bit can_take;
        can_take = q.size() < 2;
        if (q.size() > 0 && !r) begin
            m_stall  = sat(m_stall, (1 << CNT_W) - 1);
            m_stall2 = sat(m_stall2, 3);
        end
        if (f) begin
            if (q.size() > 0) begin
                m_flush  = sat(m_flush, (1 << CNT_W) - 1);
                m_flush2 = sat(m_flush2, 3);
            end
            q.delete();
        end else begin
            if (q.size() > 0 && r) void'(q.pop_front());
            if (v && can_take) q.push_back('{instr: i, addr: a});
        end
    endtask

    // Called at posedge+1: drive, check mid-cycle, advance one edge.
    task automatic cycle(input string tag, input logic v, input logic [W-1:0] i,
                         input logic [W-1:0] a, input logic r, input logic f);
        inp_valid = v; inp_instruction = i; inp_address = a; inp_ready = r; inp_flush = f;
        #3;
        check_outputs(tag);
        @(posedge clk);
        model_edge(v, i, a, r, f);
        #1;
    endtask

    task automatic clear_model();
        q.delete();
        m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;
    endtask

    initial begin
        int s0;
        clear_model();

        // Reset with a valid instruction presented: nothing captured.
        rst = 1'b1; inp_valid = 1'b1; inp_instruction = 16'd2; inp_address = 16'd2; inp_ready = 1'b1;
        #1;
        check_outputs("reset");
        @(posedge clk); #1;
        check_outputs("reset_edge");
        rst = 1'b0;
        cycle("idle0", 1'b0, 16'd2, 16'd2, 1'b1, 1'b0);
        cycle("idle1", 1'b0, 16'd2, 16'd2, 1'b1, 1'b0);

        // Streaming, decode always ready.
        cycle("str0", 1'b1, 16'd2,   16'd3,   1'b1, 1'b0);
        cycle("str1", 1'b1, 16'd20,  16'd30,  1'b1, 1'b0);
        cycle("str2", 1'b1, 16'd100, 16'd200, 1'b1, 1'b0);
        cycle("str3", 1'b1, 16'd255, 16'd127, 1'b1, 1'b0);
        chk("str.head_instr", {16'd0, out_instruction}, 32'd255);
        cycle("str4", 1'b0, 16'd0,   16'd0,   1'b1, 1'b0);

        // Back-pressure: skid fills, outputs hold, then drain in order.
        cycle("bp0", 1'b1, 16'd20,  16'd30,  1'b0, 1'b0);
        cycle("bp1", 1'b1, 16'd100, 16'd200, 1'b0, 1'b0);
        chk("bp.ready_low", {31'd0, out_ready}, 32'd0);
        chk("bp.hold_addr", {16'd0, out_address}, 32'd30);
        cycle("bp2", 1'b1, 16'd100, 16'd200, 1'b0, 1'b0);
        cycle("bp3", 1'b0, 16'd0,   16'd0,   1'b1, 1'b0);
        chk("bp.second", {16'd0, out_instruction}, 32'd100);
        cycle("bp4", 1'b0, 16'd0,   16'd0,   1'b1, 1'b0);
        cycle("bp5", 1'b0, 16'd0,   16'd0,   1'b1, 1'b0);

        // Flush with full main and skid plus a valid incoming entry.
        cycle("fl0", 1'b1, 16'd100, 16'd200, 1'b0, 1'b0);
        cycle("fl1", 1'b1, 16'd255, 16'd127, 1'b0, 1'b0);
        cycle("fl2", 1'b1, 16'd0,   16'd0,   1'b1, 1'b1);
        chk("fl.valid", {31'd0, out_valid}, 32'd0);
        chk("fl.ready", {31'd0, out_ready}, 32'd1);
        cycle("fl3", 1'b0, 16'd0,   16'd0,   1'b1, 1'b1); // flush while empty

        // Stall counting: one entry, decode stalled 5 cycles.
        s0 = m_stall;
        cycle("st0", 1'b1, 16'h1234, 16'h0042, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cycle("st", 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        cycle("st_end", 1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        chk("st.delta", 32'(m_stall - s0), 32'd5);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            cycle("rnd", 1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end

        // Async reset between edges with entries held.
        cycle("ar0", 1'b1, 16'hBEEF, 16'h0101, 1'b0, 1'b0);
        cycle("ar1", 1'b1, 16'hCAFE, 16'h0202, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        clear_model();
        chk("arst.valid", {31'd0, out_valid}, 32'd0);
        chk("arst.instr", {16'd0, out_instruction}, 32'd0);
        chk("arst.addr",  {16'd0, out_address}, 32'd0);
        chk("arst.ready", {31'd0, out_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        cycle("post0", 1'b1, 16'h0007, 16'h0008, 1'b1, 1'b0);
        cycle("post1", 1'b0, 16'd0, 16'd0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
